reg6_cnt: RTL and testbench

- 6-bit loadable up/down register: parallel load (set), increment (inc) or decrement (dec), one operation per clock.
- General-purpose counter/pointer register in the CPU memory subsystem, e.g. a small address or stack pointer.
- Single clock domain, asynchronous active-high reset.
- Status flags let surrounding control logic test zero, maximum and wrap events without extra comparators.

---
 rtl/reg6_pkg.sv | 31 +++
 rtl/reg6_cnt_if.sv | 31 +++
 rtl/reg6_next.sv | 56 +++++
 rtl/reg6_cnt.sv | 62 ++++++
 tb/tb_reg6_cnt.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/reg6_pkg.sv
// Shared definitions for the reg6_cnt loadable up/down register.
// Contents:
//   DEFAULT_WIDTH - default register width in bits
//   op_e          - one operation per clock edge: hold, load, increment, decrement
//   decode_op     - turns the raw set/inc/dec request levels into one op_e value
package reg6_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

    // set wins over everything. inc and dec asserted together cancel to a hold.
    function automatic op_e decode_op(input logic set, input logic inc, input logic dec);
        op_e op;
        if (set)
            op = OP_LOAD;
        else if (inc && !dec)
            op = OP_INC;
        else if (dec && !inc)
            op = OP_DEC;
        else
            op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/reg6_cnt_if.sv
// Request/status bundle for reg6_cnt.
//   set, D, inc, dec : requests from the controlling logic (master -> slave)
//   Q                : registered register value (slave -> master)
//   is_zero, is_max  : flags derived from Q only (slave -> master)
//   wrap             : registered one-cycle overflow/underflow pulse (slave -> master)
interface reg6_cnt_if
    import reg6_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             set;
    logic [WIDTH-1:0] D;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] Q;
    logic             is_zero;
    logic             is_max;
    logic             wrap;

    modport master (
        output set, D, inc, dec,
        input  Q, is_zero, is_max, wrap
    );

    modport slave (
        input  set, D, inc, dec,
        output Q, is_zero, is_max, wrap
    );

endinterface

// File: rtl/reg6_next.sv
// Combinational next-value and wrap computation for reg6_cnt.
// Ports:
//   op        - decoded operation for this edge
//   q         - current register value
//   d         - parallel load data
//   q_next    - value the register takes on the next edge
//   wrap_next - 1 when this update overflows or underflows in wrap mode
module reg6_next
    import reg6_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        case (op)
            OP_LOAD: q_next = d;
            OP_INC: begin
                if (q == MAX_VAL) begin
                    // Clamp mode leaves q at the maximum and reports no wrap.
                    if (!SATURATE) begin
                        q_next    = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (q == '0) begin
                    if (!SATURATE) begin
                        q_next    = MAX_VAL;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
            default: begin
                q_next    = q;
                wrap_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg6_cnt.sv
// Loadable up/down register for small pointers in the memory subsystem.
// Each clock edge performs one of load, increment, decrement or hold.
// Priority is set, then inc, then dec. inc and dec together hold the value.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; Q = RESET_VAL and wrap = 0 while it is high
//   bus - slave side of reg6_cnt_if (set/D/inc/dec in, Q/is_zero/is_max/wrap out)
// Parameters:
//   WIDTH     - register width in bits
//   RESET_VAL - value Q takes during reset
//   SATURATE  - 0 wraps modulo 2^WIDTH; 1 clamps at 0 and at 2^WIDTH-1
module reg6_cnt
    import reg6_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    reg6_cnt_if.slave  bus
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    op_e              op;

    assign op = decode_op(bus.set, bus.inc, bus.dec);

    reg6_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .op        (op),
        .q         (q_reg),
        .d         (bus.D),
        .q_next    (q_next),
        .wrap_next (wrap_next)
    );

    // wrap_next is 0 for every operation except a wrapping inc or dec.
    // Because of that, wrap_reg clears on loads and holds without extra logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= RESET_VAL;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    // The flags depend only on the register, so no input reaches an output
    // through a combinational path.
    assign bus.Q       = q_reg;
    assign bus.wrap    = wrap_reg;
    assign bus.is_zero = (q_reg == '0);
    assign bus.is_max  = &q_reg;

endmodule

// File: tb/tb_reg6_cnt.sv
module tb_reg6_cnt;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg6_cnt_if #(.WIDTH(6)) bus0 ();
    reg6_cnt_if #(.WIDTH(6)) bus1 ();

    // dut0: wrap mode, dut1: clamp mode
    reg6_cnt #(.WIDTH(6), .RESET_VAL(6'd0), .SATURATE(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    reg6_cnt #(.WIDTH(6), .RESET_VAL(6'd0), .SATURATE(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        int         sel;
        logic [5:0] q;
        logic       wrap;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [5:0] get_q(input int sel);
        return (sel == 0) ? bus0.Q : bus1.Q;
    endfunction

    function automatic logic get_wrap(input int sel);
        return (sel == 0) ? bus0.wrap : bus1.wrap;
    endfunction

    function automatic logic get_zero(input int sel);
        return (sel == 0) ? bus0.is_zero : bus1.is_zero;
    endfunction

    function automatic logic get_max(input int sel);
        return (sel == 0) ? bus0.is_max : bus1.is_max;
    endfunction

    // Monitor: each queued expectation describes the state after the next rising edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.name, ".q"},    get_q(mon_e.sel), mon_e.q);
            chk({mon_e.name, ".wrap"}, 6'(get_wrap(mon_e.sel)), 6'(mon_e.wrap));
            chk({mon_e.name, ".zero"}, 6'(get_zero(mon_e.sel)), 6'(mon_e.q == 6'd0));
            chk({mon_e.name, ".max"},  6'(get_max(mon_e.sel)),  6'(mon_e.q == 6'd63));
            $display("txn dut%0d %s q=%0d wrap=%0d", mon_e.sel, mon_e.name,
                     get_q(mon_e.sel), get_wrap(mon_e.sel));
        end
    end

    task automatic drive(input int sel, input logic s, input logic [5:0] d,
                         input logic i, input logic dc);
        bus0.set = 1'b0; bus0.D = 6'd0; bus0.inc = 1'b0; bus0.dec = 1'b0;
        bus1.set = 1'b0; bus1.D = 6'd0; bus1.inc = 1'b0; bus1.dec = 1'b0;
        if (sel == 0) begin
            bus0.set = s; bus0.D = d; bus0.inc = i; bus0.dec = dc;
        end else begin
            bus1.set = s; bus1.D = d; bus1.inc = i; bus1.dec = dc;
        end
    endtask

    task automatic step(input int sel, input logic s, input logic [5:0] d,
                        input logic i, input logic dc,
                        input logic [5:0] eq, input logic ew, input string name);
        exp_t e;
        @(negedge clk);
        drive(sel, s, d, i, dc);
        e.sel = sel; e.q = eq; e.wrap = ew; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        int waitc;
        rst = 1'b1;
        drive(0, 1'b0, 6'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        chk("rst0.q",    bus0.Q, 6'd0);
        chk("rst0.wrap", 6'(bus0.wrap), 6'd0);
        chk("rst0.zero", 6'(bus0.is_zero), 6'd1);
        chk("rst0.max",  6'(bus0.is_max), 6'd0);
        chk("rst1.q",    bus1.Q, 6'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while an increment is pending
        step(0, 1'b1, 6'd27, 1'b0, 1'b0, 6'd27, 1'b0, "pre_load");
        @(negedge clk);
        drive(0, 1'b0, 6'd0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.q",    bus0.Q, 6'd0);
        chk("async_rst.wrap", 6'(bus0.wrap), 6'd0);
        @(negedge clk);
        chk("rst_held.q", bus0.Q, 6'd0);
        drive(0, 1'b0, 6'd61, 1'b0, 1'b0);
        rst = 1'b0;
        begin
            exp_t e;
            e.sel = 0; e.q = 6'd0; e.wrap = 1'b0; e.name = "rst_release";
            sb.push_back(e);
        end

        // Load tracking
        step(0, 1'b1, 6'd61, 1'b0, 1'b0, 6'd61, 1'b0, "load61");
        step(0, 1'b1, 6'd27, 1'b0, 1'b0, 6'd27, 1'b0, "track27");
        step(0, 1'b1, 6'd56, 1'b0, 1'b0, 6'd56, 1'b0, "track56");
        step(0, 1'b1, 6'd15, 1'b0, 1'b0, 6'd15, 1'b0, "track15");
        step(0, 1'b0, 6'd27, 1'b0, 1'b0, 6'd15, 1'b0, "hold15");
        step(0, 1'b1, 6'd27, 1'b0, 1'b0, 6'd27, 1'b0, "load27");

        // Counting
        step(0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd28, 1'b0, "inc28");
        step(0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd29, 1'b0, "inc29");
        step(0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd30, 1'b0, "inc30");
        step(0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd29, 1'b0, "dec29");
        step(0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd28, 1'b0, "dec28");
        step(0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd28, 1'b0, "incdec28");

        // Priority: set beats inc and dec
        step(0, 1'b1, 6'd10, 1'b0, 1'b0, 6'd10, 1'b0, "load10");
        step(0, 1'b1, 6'd5,  1'b1, 1'b1, 6'd5,  1'b0, "prio5");

        // Wrap mode
        step(0, 1'b1, 6'd63, 1'b0, 1'b0, 6'd63, 1'b0, "load63");
        step(0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1, "ovf");
        step(0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, "ovf_clr");
        step(0, 1'b0, 6'd0,  1'b0, 1'b1, 6'd63, 1'b1, "unf");
        step(0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd63, 1'b0, "unf_clr");
        step(0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1, "ovf2");
        step(0, 1'b1, 6'd3,  1'b0, 1'b0, 6'd3,  1'b0, "load_clr");

        // Clamp mode
        step(1, 1'b1, 6'd63, 1'b0, 1'b0, 6'd63, 1'b0, "s_load63");
        step(1, 1'b0, 6'd0,  1'b1, 1'b0, 6'd63, 1'b0, "s_inc_max");
        step(1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd62, 1'b0, "s_dec62");
        step(1, 1'b1, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, "s_load0");
        step(1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd0,  1'b0, "s_dec_min");
        step(1, 1'b0, 6'd0,  1'b1, 1'b0, 6'd1,  1'b0, "s_inc1");

        @(negedge clk);
        drive(0, 1'b0, 6'd0, 1'b0, 1'b0);
        waitc = 0;
        while (sb.size() > 0 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
